// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT datapath blocks and their benches.
//   DATA_WIDTH_DFLT / LOG2N_DFLT : default sample width and log2 frame length
//   state_t                      : capture controller states (FILL / HOLD)
//   FP_ONE / FP_HALF / FP_QUARTER: IEEE-754 single-precision reference words
package fft_pkg;

  localparam int DATA_WIDTH_DFLT = 32;
  localparam int LOG2N_DFLT      = 12;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_HALF    = 32'h3F00_0000;
  localparam logic [31:0] FP_QUARTER = 32'h3E80_0000;

endpackage

// File: rtl/mem_output_if.sv
// mem_output_if: write/read/control bundle of the FFT output capture buffer.
//   master : drives clear, wr_ena, wr_data, rd_ena, rd_addr
//            (FFT core on the write side, host/harness on the read side)
//   slave  : the capture buffer; returns wr_ready, frame_done, overrun,
//            rd_data, rd_valid
interface mem_output_if
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int LOG2N      = LOG2N_DFLT
);

  logic                  clear;
  logic                  wr_ena;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  frame_done;
  logic                  overrun;
  logic                  rd_ena;
  logic [LOG2N-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output clear, wr_ena, wr_data, rd_ena, rd_addr,
    input  wr_ready, frame_done, overrun, rd_data, rd_valid
  );

  modport slave (
    input  clear, wr_ena, wr_data, rd_ena, rd_addr,
    output wr_ready, frame_done, overrun, rd_data, rd_valid
  );

endinterface

// File: rtl/bit_reverse.sv
// bit_reverse: combinational bit-order reversal, dout[i] = din[W-1-i].
//   din  : W-bit input word
//   dout : W-bit reversed word
module bit_reverse #(
  parameter int W = 12
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < W; i++) begin
      dout[i] = din[W-1-i];
    end
  end

endmodule

// File: rtl/mem_output.sv
// mem_output: capture buffer at the output end of the FFT datapath.
// Stores NPTS = 2^LOG2N sample words, one per accepted write, at the write
// count or its bit reversal, then freezes the frame for random-access reads.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (control and read port; the
//         sample array itself is never reset)
//   bus : mem_output_if slave port
//         clear            - discard frame, re-arm capture
//         wr_ena/wr_data   - sample write from the last butterfly stage
//         wr_ready         - registered, high while a write will be taken
//         frame_done       - registered level, frame complete and frozen
//         overrun          - sticky, a write arrived while wr_ready was low
//         rd_ena/rd_addr   - readback request (honoured in HOLD only)
//         rd_data/rd_valid - registered read data, one-cycle qualifier
module mem_output
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int LOG2N      = LOG2N_DFLT,
  parameter bit BITREV     = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mem_output_if.slave bus
);

  localparam int NPTS = 1 << LOG2N;

  state_t                state, state_nxt;
  logic [LOG2N-1:0]      wr_cnt, wr_cnt_nxt;
  logic [LOG2N-1:0]      cnt_rev;
  logic [LOG2N-1:0]      waddr;
  logic                  wr_ready_q, wr_ready_nxt;
  logic                  frame_done_q, frame_done_nxt;
  logic                  overrun_q, overrun_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  last_wr;
  logic [DATA_WIDTH-1:0] mem [NPTS];
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  bit_reverse #(
    .W (LOG2N)
  ) u_wr_rev (
    .din  (wr_cnt),
    .dout (cnt_rev)
  );

  assign waddr   = BITREV ? cnt_rev : wr_cnt;
  assign last_wr = (wr_cnt == {LOG2N{1'b1}});

  // clear has priority over both ports: a coincident write or read is dropped.
  assign wr_acc = (state == FILL) && bus.wr_ena && wr_ready_q && !bus.clear;
  assign rd_acc = (state == HOLD) && bus.rd_ena && !bus.clear;

  always_comb begin
    state_nxt      = state;
    wr_cnt_nxt     = wr_cnt;
    wr_ready_nxt   = wr_ready_q;
    frame_done_nxt = frame_done_q;
    overrun_nxt    = overrun_q;
    if (bus.clear) begin
      state_nxt      = FILL;
      wr_cnt_nxt     = '0;
      wr_ready_nxt   = 1'b1;
      frame_done_nxt = 1'b0;
      overrun_nxt    = 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (wr_acc) begin
            if (last_wr) begin
              state_nxt      = HOLD;
              wr_cnt_nxt     = '0;
              wr_ready_nxt   = 1'b0;
              frame_done_nxt = 1'b1;
            end else begin
              wr_cnt_nxt = wr_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.wr_ena && !wr_ready_q) begin
            overrun_nxt = 1'b1;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL;
      wr_cnt       <= '0;
      wr_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_cnt       <= wr_cnt_nxt;
      wr_ready_q   <= wr_ready_nxt;
      frame_done_q <= frame_done_nxt;
      overrun_q    <= overrun_nxt;
    end
  end

  // ---- stage p0 -> array: sample write ----
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[waddr] <= bus.wr_data;
    end
  end

  // ---- stage p0 -> p1: registered readback, data holds when idle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) begin
        rd_data_p1 <= mem[bus.rd_addr];
      end
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.rd_data    = rd_data_p1;
  assign bus.rd_valid   = vld_p1;

endmodule

// File: tb/tb_mem_output.sv
// tb_mem_output: bench for mem_output with an 8-point frame. Two instances
// share one stimulus stream: u_rev (BITREV=1) and u_nat (BITREV=0). A
// frame-level reference model (arrays indexed by the write count and its
// reversal) predicts every output after every clock edge.
module tb_mem_output;
  import fft_pkg::*;

  localparam int DW = 32;
  localparam int LN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          wr_ena;
  logic [DW-1:0] wr_data;
  logic          rd_ena;
  logic [LN-1:0] rd_addr;

  mem_output_if #(.DATA_WIDTH(DW), .LOG2N(LN)) bus_r ();
  mem_output_if #(.DATA_WIDTH(DW), .LOG2N(LN)) bus_n ();

  assign bus_r.clear   = clear;
  assign bus_r.wr_ena  = wr_ena;
  assign bus_r.wr_data = wr_data;
  assign bus_r.rd_ena  = rd_ena;
  assign bus_r.rd_addr = rd_addr;
  assign bus_n.clear   = clear;
  assign bus_n.wr_ena  = wr_ena;
  assign bus_n.wr_data = wr_data;
  assign bus_n.rd_ena  = rd_ena;
  assign bus_n.rd_addr = rd_addr;

  mem_output #(.DATA_WIDTH(DW), .LOG2N(LN), .BITREV(1'b1)) u_rev (
    .clk (clk),
    .rst (rst),
    .bus (bus_r)
  );

  mem_output #(.DATA_WIDTH(DW), .LOG2N(LN), .BITREV(1'b0)) u_nat (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit          m_hold;
  int          m_cnt;
  bit          m_ovr;
  bit          m_rv;
  logic [31:0] m_rd_r, m_rd_n;
  logic [31:0] m_mem_r [8];
  logic [31:0] m_mem_n [8];

  typedef struct {
    logic [LN-1:0] addr;
    logic [31:0]   exp;
  } rd_vec_t;

  rd_vec_t t1 [8];

  function automatic int rev3(int a);
    return ((a & 1) << 2) | (a & 2) | ((a >> 2) & 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_hold = 0; m_cnt = 0; m_ovr = 0; m_rv = 0; m_rd_r = '0; m_rd_n = '0;
  endtask

  // Frame-level rules applied to the inputs present at the coming edge.
  task automatic model_step();
    if (clear) begin
      m_hold = 0; m_cnt = 0; m_ovr = 0; m_rv = 0;
    end else if (!m_hold) begin
      m_rv = 0;
      if (wr_ena) begin
        m_mem_n[m_cnt]       = wr_data;
        m_mem_r[rev3(m_cnt)] = wr_data;
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt  = 0;
          m_hold = 1;
        end
      end
    end else begin
      if (wr_ena) m_ovr = 1;
      m_rv = rd_ena;
      if (rd_ena) begin
        m_rd_r = m_mem_r[int'(rd_addr)];
        m_rd_n = m_mem_n[int'(rd_addr)];
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".wr_ready_r"},   bus_r.wr_ready,   !m_hold);
    chk({tag, ".frame_done_r"}, bus_r.frame_done, m_hold);
    chk({tag, ".overrun_r"},    bus_r.overrun,    m_ovr);
    chk({tag, ".rd_valid_r"},   bus_r.rd_valid,   m_rv);
    chk({tag, ".rd_data_r"},    bus_r.rd_data,    m_rd_r);
    chk({tag, ".wr_ready_n"},   bus_n.wr_ready,   !m_hold);
    chk({tag, ".frame_done_n"}, bus_n.frame_done, m_hold);
    chk({tag, ".overrun_n"},    bus_n.overrun,    m_ovr);
    chk({tag, ".rd_valid_n"},   bus_n.rd_valid,   m_rv);
    chk({tag, ".rd_data_n"},    bus_n.rd_data,    m_rd_n);
  endtask

  task automatic cycle(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wr(logic [31:0] d, string tag);
    wr_ena = 1'b1; wr_data = d;
    cycle(tag);
    wr_ena = 1'b0;
  endtask

  task automatic rd(int a, string tag);
    rd_ena = 1'b1; rd_addr = LN'(a);
    cycle(tag);
    rd_ena = 1'b0;
  endtask

  task automatic do_clear(string tag);
    clear = 1'b1;
    cycle(tag);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_ena = 1'b0; wr_data = '0;
    rd_ena = 1'b0; rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset");
    chk("reset.wr_ready", bus_r.wr_ready, 1'b1);
    chk("reset.rd_data",  bus_r.rd_data,  32'h0);

    // 1: bit-reversed fill of 1..8, then table-driven readback
    t1[0] = '{3'd0, 32'd1}; t1[1] = '{3'd1, 32'd5};
    t1[2] = '{3'd2, 32'd3}; t1[3] = '{3'd3, 32'd7};
    t1[4] = '{3'd4, 32'd2}; t1[5] = '{3'd5, 32'd6};
    t1[6] = '{3'd6, 32'd4}; t1[7] = '{3'd7, 32'd8};
    for (int i = 0; i < 8; i++) begin
      wr(32'(i + 1), "t1.wr");
      if (i == 6) chk("t1.done_before_last", bus_r.frame_done, 1'b0);
    end
    chk("t1.frame_done", bus_r.frame_done, 1'b1);
    chk("t1.wr_ready",   bus_r.wr_ready,   1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_ena = 1'b1; rd_addr = t1[i].addr;
      cycle("t1.rd");
      chk("t1.rd_data",  bus_r.rd_data,  t1[i].exp);
      chk("t1.rd_valid", bus_r.rd_valid, 1'b1);
    end
    rd_ena = 1'b0;
    cycle("t1.idle");
    chk("t1.rd_valid_idle", bus_r.rd_valid, 1'b0);
    chk("t1.rd_data_hold",  bus_r.rd_data,  32'd8);

    // 2: float words, natural order; rd_ena held during FILL
    do_clear("t2.clear");
    rd_ena = 1'b1; rd_addr = '0;
    for (int i = 0; i < 8; i++) begin
      wr_ena = 1'b1;
      wr_data = (i == 0) ? FP_ONE : (i == 1) ? FP_HALF : (i == 2) ? FP_QUARTER : 32'h0;
      cycle("t2.wr");
      chk("t2.no_valid_in_fill", bus_n.rd_valid, 1'b0);
    end
    wr_ena = 1'b0; rd_ena = 1'b0;
    rd(0, "t2.rd0"); chk("t2.nat0", bus_n.rd_data, FP_ONE);     chk("t2.rev0", bus_r.rd_data, FP_ONE);
    rd(1, "t2.rd1"); chk("t2.nat1", bus_n.rd_data, FP_HALF);
    rd(4, "t2.rd4"); chk("t2.rev4", bus_r.rd_data, FP_HALF);
    rd(2, "t2.rd2"); chk("t2.nat2", bus_n.rd_data, FP_QUARTER); chk("t2.rev2", bus_r.rd_data, FP_QUARTER);

    // 3: overrun in HOLD, frame untouched, clear re-arms
    wr(32'hDEAD_BEEF, "t3.ovr");
    chk("t3.overrun", bus_r.overrun, 1'b1);
    for (int a = 0; a < 8; a++) rd(a, "t3.rd");
    cycle("t3.idle");
    do_clear("t3.clear");
    chk("t3.overrun_clr", bus_r.overrun,    1'b0);
    chk("t3.done_clr",    bus_r.frame_done, 1'b0);
    chk("t3.ready_clr",   bus_r.wr_ready,   1'b1);

    // 4: clear collides with the 4th write
    for (int i = 0; i < 3; i++) wr(32'h100 + 32'(i), "t4.pre");
    clear = 1'b1; wr_ena = 1'b1; wr_data = 32'h103;
    cycle("t4.clear_wr");
    clear = 1'b0; wr_ena = 1'b0;
    chk("t4.overrun", bus_r.overrun, 1'b0);
    for (int i = 0; i < 8; i++) wr(32'h200 + 32'(i), "t4.wr");
    chk("t4.frame_done", bus_r.frame_done, 1'b1);
    rd(0, "t4.rd0");
    chk("t4.first_at0_r", bus_r.rd_data, 32'h200);
    chk("t4.first_at0_n", bus_n.rd_data, 32'h200);

    // 5: asynchronous reset mid-frame
    do_clear("t5.clear");
    for (int i = 0; i < 5; i++) wr(32'h300 + 32'(i), "t5.pre");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("t5.async_rst");
    chk("t5.rd_data_rst", bus_r.rd_data, 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(32'(i + 1), "t5.wr");
      if (i == 6) chk("t5.not_done7", bus_r.frame_done, 1'b0);
    end
    chk("t5.done8", bus_r.frame_done, 1'b1);

    // 6: back-to-back reads 7 then 0
    rd_ena = 1'b1; rd_addr = 3'd7;
    cycle("t6.rd7");
    chk("t6.data7",  bus_r.rd_data,  32'd8);
    chk("t6.valid7", bus_r.rd_valid, 1'b1);
    rd_addr = 3'd0;
    cycle("t6.rd0");
    chk("t6.data0",  bus_r.rd_data,  32'd1);
    chk("t6.valid0", bus_r.rd_valid, 1'b1);
    rd_ena = 1'b0;

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      clear   = ($urandom_range(0, 99) < 3);
      wr_ena  = ($urandom_range(0, 99) < 60);
      wr_data = $urandom;
      rd_ena  = ($urandom_range(0, 99) < 50);
      rd_addr = LN'($urandom_range(0, 7));
      cycle("rand");
    end
    clear = 1'b0; wr_ena = 1'b0; rd_ena = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
